// File: rtl/deserializer.sv
// Serial-to-parallel receiver: packs MSB-first valid-qualified bits into DATA_W-bit words with a bit count.
// Optional idle flush of partial words when DESER_TIMEOUT_EN is defined.
module deserializer #(
    parameter int DATA_W  = 16,
    parameter int MOD_W   = $clog2(DATA_W) + 1,
    parameter int TIMEOUT = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    input  logic              ser_last_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam logic [DATA_W-1:0] TOP_BIT = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [MOD_W-1:0]  FULL    = MOD_W'(DATA_W);

    typedef enum logic [0:0] {S_IDLE, S_COLLECT} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [MOD_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bit_mask;
    logic              done;
    logic              flush;

    logic [DATA_W-1:0] data_q;
    logic [MOD_W-1:0]  mod_q;
    logic              val_q;
    logic              busy_q;
    logic              to_q;

`ifdef DESER_TIMEOUT_EN
    localparam int              IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    logic [IDLE_W-1:0] idle_q;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT[0];
`endif

    // Unfilled LSBs of shift_q are always zero, so a bit is placed by OR-ing a walking mask.
    always_comb begin
        bit_mask = TOP_BIT >> cnt_q;
        shift_d  = shift_q;
        if (ser_data_i) shift_d = shift_q | bit_mask;
        cnt_d = cnt_q + 1'b1;
        done  = ser_data_val_i && (ser_last_i || (cnt_d == FULL));
        flush = 1'b0;
`ifdef DESER_TIMEOUT_EN
        // A valid bit on the would-be timeout cycle takes priority over the flush.
        flush = (state_q == S_COLLECT) && !ser_data_val_i && (idle_q == IDLE_LAST);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
`ifdef DESER_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            val_q <= 1'b0;
            to_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ser_data_val_i) begin
                        if (done) begin
                            data_q  <= shift_d;
                            mod_q   <= cnt_d;
                            val_q   <= 1'b1;
                            shift_q <= '0;
                            cnt_q   <= '0;
                        end else begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                            busy_q  <= 1'b1;
                            state_q <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (ser_data_val_i) begin
`ifdef DESER_TIMEOUT_EN
                        idle_q <= '0;
`endif
                        if (done) begin
                            data_q  <= shift_d;
                            mod_q   <= cnt_d;
                            val_q   <= 1'b1;
                            shift_q <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                        end
                    end else if (flush) begin
                        data_q  <= shift_q;
                        mod_q   <= cnt_q;
                        val_q   <= 1'b1;
                        to_q    <= 1'b1;
                        shift_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`ifdef DESER_TIMEOUT_EN
                        idle_q  <= '0;
`endif
                    end else begin
`ifdef DESER_TIMEOUT_EN
                        idle_q <= idle_q + 1'b1;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;
    assign busy_o           = busy_q;
`ifdef DESER_TIMEOUT_EN
    assign timeout_o        = to_q;
`else
    assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Randomized bench for deserializer against a bit-list reference model; checks every cycle.
module tb_deserializer;
    localparam int DW = 16;
    localparam int MW = 5;
    localparam int TO = 32;
`ifdef DESER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, d = 1'b0, v = 1'b0, l = 1'b0;
    logic [DW-1:0] dout;
    logic [MW-1:0] mod;
    logic dval, busy, tout;

    deserializer #(.DATA_W(DW), .MOD_W(MW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ser_data_i(d), .ser_data_val_i(v), .ser_last_i(l),
        .deser_data_o(dout), .deser_data_mod_o(mod), .deser_data_val_o(dval),
        .busy_o(busy), .timeout_o(tout)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    bit mbits[$];
    int idle = 0;
    bit exp_pulse, exp_to;
    logic [DW-1:0] exp_data = '0;
    int exp_mod = 0;
    int pcyc[$];
    bit saw_to = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void emit(input bit to);
        exp_data = '0;
        for (int k = 0; k < mbits.size(); k++) exp_data[DW-1-k] = mbits[k];
        exp_mod   = mbits.size();
        exp_pulse = 1'b1;
        exp_to    = to;
        mbits.delete();
        idle = 0;
    endfunction

    // Drive one cycle, advance the model on the edge, then check all outputs.
    task automatic step(input bit vv, input bit dd, input bit ll);
        v = vv; d = dd; l = ll;
        @(posedge clk);
        exp_pulse = 1'b0;
        exp_to    = 1'b0;
        if (vv) begin
            mbits.push_back(dd);
            idle = 0;
            if (ll || mbits.size() == DW) emit(1'b0);
        end else if (mbits.size() != 0) begin
            idle++;
            if (TO_EN && idle == TO) emit(1'b1);
        end
        cyc++;
        #1;
        chk("val", dval, exp_pulse);
        chk("busy", busy, mbits.size() != 0);
        chk("timeout", tout, exp_to);
        chk("data_hold", dout, exp_data);
        chk("mod_hold", mod, exp_mod);
        if (exp_pulse) begin
            pcyc.push_back(cyc);
            if (exp_to) saw_to = 1'b1;
        end
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int n, input bit last, input int maxhole);
        for (int i = 0; i < n; i++) begin
            int holes;
            holes = (maxhole > 0) ? $urandom_range(maxhole, 0) : 0;
            for (int h = 0; h < holes; h++) step(1'b0, 1'($urandom), 1'($urandom));
            step(1'b1, w[DW-1-i], last && (i == n-1));
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_data", dout, 0);
        chk("rst_mod", mod, 0);
        chk("rst_val", dval, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tout", tout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full word
        send_bits(16'hA5C3, 16, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0);

        // Short frames ended by last
        send_bits(16'hB000, 5, 1'b1, 0);
        send_bits(16'h8000, 1, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0);

        // Back-to-back words
        pcyc.delete();
        send_bits(16'h1234, 16, 1'b0, 0);
        send_bits(16'hFFFF, 16, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("b2b_count", pcyc.size(), 2);
        if (pcyc.size() == 2) chk("b2b_gap", pcyc[1] - pcyc[0], 16);

        // Holes with stray last on idle cycles
        pcyc.delete();
        send_bits(16'h00FF, 16, 1'b0, 3);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("holes_count", pcyc.size(), 1);

        // Asynchronous reset mid-word
        send_bits(16'hFE00, 7, 1'b0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_data", dout, 0);
        chk("arst_mod", mod, 0);
        chk("arst_val", dval, 0);
        chk("arst_busy", busy, 0);
        mbits.delete();
        idle = 0;
        exp_data = '0;
        exp_mod = 0;
        @(negedge clk);
        rst_n = 1'b1;
        pcyc.delete();
        send_bits(16'h5555, 16, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("post_rst_count", pcyc.size(), 1);

        // Idle flush: 3 bits then TIMEOUT idle cycles
        pcyc.delete();
        saw_to = 1'b0;
        send_bits(16'hA000, 3, 1'b0, 0);
        repeat (TO) step(1'b0, 1'b0, 1'b0);
`ifdef DESER_TIMEOUT_EN
        chk("to_pulse", pcyc.size(), 1);
        chk("to_flag", saw_to, 1);
        chk("to_data", dout, 16'hA000);
        chk("to_mod", mod, 3);
`else
        repeat (8) step(1'b0, 1'b0, 1'b0);
        chk("no_to_pulse", pcyc.size(), 0);
        chk("no_to_busy", busy, 1);
`endif
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Valid bit on the would-be timeout cycle wins
        send_bits(16'hA000, 3, 1'b0, 0);
        repeat (TO-1) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("bitwins_mod", mod, 4);
        chk("bitwins_data", dout, 16'hB000);
        chk("bitwins_tout", tout, 0);
        step(1'b0, 1'b0, 1'b0);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            int n;
            bit lst;
            n = $urandom_range(DW, 1);
            lst = (n < DW) ? 1'b1 : 1'($urandom);
            send_bits(16'($urandom), n, lst, $urandom_range(2, 0));
            if ($urandom_range(3, 0) == 0) step(1'b0, 1'b0, 1'($urandom));
        end
        step(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
